// File: rtl/rom_burst_reader.sv
// Block-read sequencer for a 1-cycle-latency synchronous ROM; optional running checksum when ROM_BURST_CHECKSUM_EN is defined.
// Latency: first word on out_valid two edges after the edge that accepts start; one word per clk once streaming.
// Backpressure: out_ready stalls the head of a 2-entry buffer, and reads are issued only while a buffer slot is guaranteed.

// Generic synchronous FIFO, first-word-fall-through.
// Latency: a written word is visible at rd_dat the cycle after wr_vld.
// Backpressure: the writer must not push when full unless popping in the same cycle.
module rbr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    output logic [CW-1:0]    count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    assign rd_vld = (count != '0);
    assign do_pop = rd_vld && rd_rdy;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
            end
            case ({wr_vld, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// Streams `length` consecutive ROM words from base_addr over valid/ready.
// Latency: out_valid rises two edges after start is accepted; done is a 1-clk pulse after the final accept.
// Backpressure: out_ready low holds out_data; at most two reads are outstanding beyond the accepted count.
module rom_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef ROM_BURST_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    logic [1:0]            state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issued_cnt;
    logic [LEN_WIDTH-1:0]  accepted_cnt;
    logic [ADDR_WIDTH-1:0] issue_ptr;
    logic                  inflight;
    logic [1:0]            buf_count;
    logic                  pop;
    logic                  issue;
    logic                  last_pop;

    assign pop      = out_valid && out_ready;
    // A pop in the same cycle frees the slot the new read will land in.
    assign issue    = (state == ST_RUN) && (issued_cnt < len_q) &&
                      (((buf_count + {1'b0, inflight}) < 2'd2) || pop);
    assign last_pop = pop && (accepted_cnt == len_q - LEN_ONE);

    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_DONE);
    assign rom_addr = issue_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            len_q        <= '0;
            issued_cnt   <= '0;
            accepted_cnt <= '0;
            issue_ptr    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_RUN;
                        len_q        <= length;
                        issue_ptr    <= base_addr;
                        issued_cnt   <= '0;
                        accepted_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        issue_ptr  <= issue_ptr + ADDR_ONE;
                        issued_cnt <= issued_cnt + LEN_ONE;
                    end
                    if (pop) begin
                        accepted_cnt <= accepted_cnt + LEN_ONE;
                    end
                    // A zero-length burst spends a single busy cycle here.
                    if ((len_q == '0) || last_pop) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
        end
    end

    rbr_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (2),
        .CW    (2)
    ) u_buf (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (inflight),
        .wr_dat (rom_q),
        .rd_rdy (out_ready),
        .rd_vld (out_valid),
        .rd_dat (out_data),
        .count  (buf_count)
    );

`ifdef ROM_BURST_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if ((state == ST_IDLE) && start) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum + out_data;
        end
    end
`endif
endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader against a 128-word ROM holding its own address.
module tb_rom_burst_reader;
    logic       clk;
    logic       reset;
    logic       start;
    logic [6:0] base_addr;
    logic [7:0] length;
    logic       busy;
    logic       done;
    logic [6:0] rom_addr;
    logic [7:0] rom_q;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
`ifdef ROM_BURST_CHECKSUM_EN
    logic [7:0] checksum;
    logic [7:0] cks_at_done;
`endif

    logic [7:0] rom_mem [128];

    int errors = 0;
    int checks = 0;

    int         acc_q[$];
    logic [6:0] addr_q[$];
    int first_vld, last_acc, done_cyc, busy_bad, stall_bad, max_ahead, vld_seen;

    rom_burst_reader #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (7),
        .LEN_WIDTH  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ROM_BURST_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int i = 0; i < 128; i++) rom_mem[i] = 8'(i);
        rom_q = 8'h00;
    end

    always @(posedge clk) rom_q <= rom_mem[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_words(input string tag, input logic [6:0] b, input int n);
        chk({tag, "_nwords"}, acc_q.size(), n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_word%0d", tag, i),
                (i < acc_q.size()) ? acc_q[i] : 32'hFFFF_FFFF, 32'((b + i) & 7'h7F));
        end
    endtask

    // Starts a burst at the current negedge and follows it cycle by cycle until done.
    task automatic run_burst(input logic [6:0] b, input logic [7:0] l,
                             input logic [3:0] pat, input int restart_cyc);
        logic       prev_stall;
        logic [7:0] prev_dat;
        logic       rdy;
        logic [6:0] ahead;
        acc_q.delete();
        addr_q.delete();
        first_vld = -1; last_acc = -1; done_cyc = -1;
        busy_bad = 0; stall_bad = 0; max_ahead = 0; vld_seen = 0;
        prev_stall = 1'b0;
        prev_dat   = 8'h00;
        start = 1'b1; base_addr = b; length = l; out_ready = pat[0];
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            start = (k == restart_cyc);
            if (start) begin
                base_addr = 7'h00;
                length    = 8'd9;
            end
            ahead = rom_addr - b - 7'(acc_q.size());
            if (int'(ahead) > max_ahead) max_ahead = int'(ahead);
            if (addr_q.size() == 0 || addr_q[$] != rom_addr) addr_q.push_back(rom_addr);
            if (prev_stall && (!out_valid || out_data != prev_dat)) stall_bad++;
            if (out_valid) begin
                vld_seen++;
                if (first_vld < 0) first_vld = k;
            end
            if (done) begin
                if (busy) busy_bad++;
            end else if (!busy) begin
                busy_bad++;
            end
            rdy = pat[(k - 1) % 4];
            out_ready = rdy;
            if (out_valid && rdy) begin
                acc_q.push_back(int'(out_data));
                last_acc = k;
            end
            prev_stall = out_valid && !rdy;
            prev_dat   = out_data;
            if (done) begin
                done_cyc = k;
`ifdef ROM_BURST_CHECKSUM_EN
                cks_at_done = checksum;
`endif
                break;
            end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rom_addr", rom_addr, 0);
`ifdef ROM_BURST_CHECKSUM_EN
        chk("rst_checksum", checksum, 0);
`endif

        // Basic burst, consumer always ready.
        run_burst(7'h10, 8'd4, 4'b1111, 0);
        chk_words("basic", 7'h10, 4);
        chk("basic_first_vld", first_vld, 3);
        chk("basic_last_acc", last_acc, 6);
        chk("basic_done_cyc", done_cyc, 7);
        chk("basic_busy_bad", busy_bad, 0);
        chk("basic_done_pulse", done, 0);
`ifdef ROM_BURST_CHECKSUM_EN
        chk("basic_checksum", cks_at_done, 8'h46);
        chk("basic_checksum_hold", checksum, 8'h46);
`endif

        // Backpressure with ready pattern 1,0,0,1 repeating.
        run_burst(7'h20, 8'd6, 4'b1001, 0);
        chk_words("bp", 7'h20, 6);
        chk("bp_stall_bad", stall_bad, 0);
        chk("bp_max_ahead", max_ahead, 2);
        chk("bp_first_vld", first_vld, 3);
        chk("bp_done_cyc", done_cyc, 14);
        chk("bp_busy_bad", busy_bad, 0);

        // Address wrap.
        run_burst(7'h7E, 8'd4, 4'b1111, 0);
        chk_words("wrap", 7'h7E, 4);
        chk("wrap_addr0", (addr_q.size() > 0) ? addr_q[0] : 7'h55, 7'h7E);
        chk("wrap_addr1", (addr_q.size() > 1) ? addr_q[1] : 7'h55, 7'h7F);
        chk("wrap_addr2", (addr_q.size() > 2) ? addr_q[2] : 7'h55, 7'h00);
        chk("wrap_addr3", (addr_q.size() > 3) ? addr_q[3] : 7'h55, 7'h01);
        chk("wrap_done_cyc", done_cyc, 7);
`ifdef ROM_BURST_CHECKSUM_EN
        chk("wrap_checksum", cks_at_done, 8'hFE);
`endif

        // Zero-length burst.
        run_burst(7'h50, 8'd0, 4'b1111, 0);
        chk("zero_vld_seen", vld_seen, 0);
        chk("zero_done_cyc", done_cyc, 2);
        chk("zero_busy_bad", busy_bad, 0);

        // Start during an active burst is ignored.
        run_burst(7'h30, 8'd3, 4'b1111, 2);
        chk_words("restart", 7'h30, 3);
        chk("restart_vld_seen", vld_seen, 3);
        chk("restart_done_cyc", done_cyc, 6);
        repeat (3) @(negedge clk);
        chk("restart_idle_busy", busy, 0);
        chk("restart_idle_valid", out_valid, 0);

        // Reset mid-burst after two words accepted.
        start = 1'b1; base_addr = 7'h40; length = 8'd8; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_pre_valid", out_valid, 1);
        chk("midrst_pre_data", out_data, 8'h42);
        chk("midrst_pre_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_rom_addr", rom_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_post_done", done, 0);
        run_burst(7'h05, 8'd2, 4'b1111, 0);
        chk_words("post", 7'h05, 2);
        chk("post_vld_seen", vld_seen, 2);
        chk("post_done_cyc", done_cyc, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
